// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor shared definitions
// fsm encodings and default operand width
package serial_subtractor_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: 1-bit borrow cell
// two half-subtractor stages joined by an or
module full_subtractor (
  output logic dif,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  logic d1;
  logic b1;
  logic b2;

  // first half stage: a - b
  assign d1 = a ^ b;
  assign b1 = ~a & b;

  // second half stage: (a - b) - bin
  assign dif = d1 ^ bin;
  assign b2  = ~d1 & bin;

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, lsb first
// one borrow cell, registered borrow, start/done handshake
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rd;
  logic [WIDTH-1:0] rd_nxt;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             borrow_nxt;
  logic             dbit;
  logic             last;
  logic             accept;

  assign last   = (cnt == CNT_LAST);
  assign accept = (state == ST_IDLE) && start;

  full_subtractor u_fs (
    .dif  (dbit),
    .bout (borrow_nxt),
    .a    (ra[0]),
    .b    (rb[0]),
    .bin  (borrow)
  );

  assign rd_nxt = {dbit, rd[WIDTH-1:1]};

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state and moore outputs; 2'd3 falls back to idle
  always_comb begin
    state_nxt = ST_IDLE;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        state_nxt = start ? ST_SHIFT : ST_IDLE;
      end
      ST_SHIFT: begin
        busy      = 1'b1;
        state_nxt = last ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // operand shifters, borrow flop and bit counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ra     <= '0;
      rb     <= '0;
      rd     <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      ra     <= a;
      rb     <= b;
      rd     <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (state == ST_SHIFT) begin
      ra     <= ra >> 1;
      rb     <= rb >> 1;
      rd     <= rd_nxt;
      borrow <= borrow_nxt;
      if (!last) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // result registers, loaded on the final shift edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d    <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
    end else if ((state == ST_SHIFT) && last) begin
      d    <= rd_nxt;
      bout <= borrow_nxt;
      zero <= (rd_nxt == '0);
    end
  end

endmodule
